// File: rtl/rx_pkg.sv
// Shared types and default constants for the receive-side packet scheduler.
//   PACKET_WIDTH   : packet length in bytes (payload is PACKET_WIDTH*8 bits)
//   packet_t       : one packet payload
//   sched_state_t  : scheduler FSM states
//   *_DEF          : default queue depth and timer limits
package rx_pkg;

    localparam int PACKET_WIDTH     = 2;
    localparam int QUEUE_DEPTH_DEF  = 4;
    localparam int UART_TIMEOUT_DEF = 2000000;
    localparam int IDLE_FLUSH_DEF   = 100000;

    typedef logic [PACKET_WIDTH*8-1:0] packet_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        GAP
    } sched_state_t;

endpackage

// File: rtl/rx_packet_scheduler_fifo.sv
// packet_fifo: circular FIFO with show-ahead read data.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : write request; accepted when not full, or when full and a read
//              happens in the same cycle (the read frees the slot)
//   rd_en    : pop request; ignored when empty
//   din/dout : write data / head of queue
//   full, empty, level : occupancy status
module packet_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             rd_fire;
    logic             wr_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/rx_packet_scheduler.sv
// rx_packet_scheduler: queues completed demodulated packets and hands them to
// the UART encoder one at a time with a start/done handshake; also pulses a
// flush of the demodulator buffer when write activity stalls.
//   clk, rst              : clock, synchronous active-high reset
//   pkt_valid, pkt_data   : completed packet from the buffer
//   demod_write           : demodulator bit-write strobe (stall detection)
//   uart_start/uart_packet: send request and the packet being sent
//   uart_done             : encoder finished the frame
//   buffer_flush          : one-cycle flush of a stalled partial packet
//   busy, overflow, timeout_err, queue_level : status
//
// state | meaning
// IDLE  | waiting for a queued packet
// LOAD  | pop queue head into the uart_packet register
// SEND  | one-cycle uart_start, arm the send timer
// WAIT  | waiting for uart_done or send timeout
// GAP   | one guaranteed idle cycle between frames
module rx_packet_scheduler #(
    parameter int PACKET_WIDTH = rx_pkg::PACKET_WIDTH,
    parameter int QUEUE_DEPTH  = rx_pkg::QUEUE_DEPTH_DEF,
    parameter int UART_TIMEOUT = rx_pkg::UART_TIMEOUT_DEF,
    parameter int IDLE_FLUSH   = rx_pkg::IDLE_FLUSH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pkt_valid,
    input  logic [PACKET_WIDTH*8-1:0]        pkt_data,
    input  logic                             demod_write,
    output logic                             uart_start,
    output logic [PACKET_WIDTH*8-1:0]        uart_packet,
    input  logic                             uart_done,
    output logic                             buffer_flush,
    output logic                             busy,
    output logic                             overflow,
    output logic                             timeout_err,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_level
);

    import rx_pkg::*;

    localparam int PW = PACKET_WIDTH*8;
    localparam int TW = $clog2(UART_TIMEOUT);
    localparam int FW = $clog2(IDLE_FLUSH);
    // Send timer terminal count lands UART_TIMEOUT cycles after uart_start.
    localparam logic [TW-1:0] TO_LOAD = TW'(UART_TIMEOUT-2);
    // Flush timer terminal count lands IDLE_FLUSH cycles after the last write.
    localparam logic [FW-1:0] FL_LOAD = FW'(IDLE_FLUSH-1);

    sched_state_t  state_q, state_d;
    logic [PW-1:0] pkt_q, pkt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [FW-1:0] fl_cnt_q, fl_cnt_d;
    logic          fl_armed_q, fl_armed_d;
    logic          overflow_q, overflow_d;
    logic          timeout_err_q, timeout_err_d;

    logic          pop;
    logic [PW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    packet_fifo #(
        .WIDTH (PW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (pkt_valid),
        .rd_en (pop),
        .din   (pkt_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (queue_level)
    );

    assign busy        = (state_q != IDLE);
    assign uart_packet = pkt_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        pkt_d         = pkt_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
        uart_start    = 1'b0;
        pop           = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                pkt_d   = fifo_dout;
                state_d = SEND;
            end
            SEND: begin
                uart_start = 1'b1;
                to_cnt_d   = TO_LOAD;
                state_d    = WAIT;
            end
            WAIT: begin
                if (uart_done) begin
                    state_d = GAP;
                end else if (to_cnt_q == '0) begin
                    // Abandon the frame; the packet is not retried.
                    timeout_err_d = 1'b1;
                    state_d       = GAP;
                end else begin
                    to_cnt_d = to_cnt_q - TW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop in the same cycle frees the slot, so only a full queue
        // without a concurrent pop drops the packet.
        overflow_d = overflow_q | (pkt_valid && fifo_full && !pop);
    end

    // Stall flush: only a demod write arms it, so an idle line after the
    // flush (or after reset) never produces a second pulse.
    always_comb begin
        fl_cnt_d     = fl_cnt_q;
        fl_armed_d   = fl_armed_q;
        buffer_flush = 1'b0;
        if (demod_write) begin
            fl_cnt_d   = FL_LOAD;
            fl_armed_d = 1'b1;
        end else if (pkt_valid) begin
            fl_cnt_d = FL_LOAD;
        end else if (fl_armed_q) begin
            if (fl_cnt_q == '0) begin
                buffer_flush = 1'b1;
                fl_armed_d   = 1'b0;
            end else begin
                fl_cnt_d = fl_cnt_q - FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pkt_q         <= '0;
            to_cnt_q      <= '0;
            fl_cnt_q      <= '0;
            fl_armed_q    <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pkt_q         <= pkt_d;
            to_cnt_q      <= to_cnt_d;
            fl_cnt_q      <= fl_cnt_d;
            fl_armed_q    <= fl_armed_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_rx_packet_scheduler.sv
// Bench for rx_packet_scheduler: PACKET_WIDTH=2, QUEUE_DEPTH=4,
// UART_TIMEOUT=16, IDLE_FLUSH=32.
module tb_rx_packet_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic [15:0] pkt_data;
    logic        demod_write;
    logic        uart_start;
    logic [15:0] uart_packet;
    logic        uart_done;
    logic        buffer_flush;
    logic        busy;
    logic        overflow;
    logic        timeout_err;
    logic [2:0]  queue_level;

    rx_packet_scheduler #(
        .PACKET_WIDTH (2),
        .QUEUE_DEPTH  (4),
        .UART_TIMEOUT (16),
        .IDLE_FLUSH   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .demod_write  (demod_write),
        .uart_start   (uart_start),
        .uart_packet  (uart_packet),
        .uart_done    (uart_done),
        .buffer_flush (buffer_flush),
        .busy         (busy),
        .overflow     (overflow),
        .timeout_err  (timeout_err),
        .queue_level  (queue_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [15:0] exp_q[$];
    int          n_vec     = 0;
    int          n_miss    = 0;
    int          n_start   = 0;
    int          n_served  = 0;
    int          cyc       = 0;
    int          last_start = -100;
    chk_t        c_m;
    logic [15:0] e_m;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: resolves queued directed checks and scores every uart_start
    // against the packet order recorded by the stimulus.
    initial begin
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c_m = chk_q.pop_front();
                n_vec++;
                if (c_m.act != c_m.exp) begin
                    n_miss++;
                    $display("FAIL %s: got %0d, expected %0d", c_m.name, c_m.act, c_m.exp);
                end
            end
            if (rst) begin
                last_start = -100;
            end else if (uart_start === 1'b1) begin
                n_start++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL uart_packet: got start with 0x%h, expected no start", uart_packet);
                end else begin
                    e_m = exp_q.pop_front();
                    if (uart_packet !== e_m) begin
                        n_miss++;
                        $display("FAIL uart_packet: got 0x%h, expected 0x%h", uart_packet, e_m);
                    end
                end
                n_vec++;
                if (cyc - last_start < 5) begin
                    n_miss++;
                    $display("FAIL start_gap: got %0d cycles, expected >= 5", cyc - last_start);
                end
                last_start = cyc;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        pkt_valid   = 1'b0;
        pkt_data    = '0;
        demod_write = 1'b0;
        uart_done   = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        rst      = 1'b0;
        n_served = n_start;
    endtask

    task automatic send_pkt(input logic [15:0] d, input bit accept);
        pkt_valid = 1'b1;
        pkt_data  = d;
        if (accept) exp_q.push_back(d);
        tick();
        pkt_valid = 1'b0;
    endtask

    task automatic wait_start(output int k);
        k = 0;
        while (uart_start !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) check("wait_start_bound", 0, 1);
    endtask

    task automatic pulse_done();
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
    endtask

    task automatic serve(input int count);
        int t;
        for (int i = 0; i < count; i++) begin
            t = 0;
            while (n_start <= n_served && t < 200) begin
                tick();
                t++;
            end
            if (t >= 200) check("serve_bound", 0, 1);
            repeat (2) tick();
            pulse_done();
            n_served++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_level", queue_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_uart_start", uart_start, 0);
        check("rst_flush", buffer_flush, 0);
        check("rst_uart_packet", uart_packet, 0);

        // Single packet
        send_pkt(16'hA5C3, 1'b1);
        wait_start(k);
        check("single_latency", k + 1, 3);
        check("single_busy", busy, 1);
        check("single_packet", uart_packet, 16'hA5C3);
        repeat (10) tick();
        pulse_done();
        n_served++;
        check("single_busy_gap", busy, 1);
        tick();
        check("single_busy_idle", busy, 0);

        // Burst of five, sixth dropped
        for (int i = 0; i < 5; i++) send_pkt(16'(16'h1111 * (i + 1)), 1'b1);
        send_pkt(16'h6666, 1'b0);
        check("burst_overflow", overflow, 1);
        check("burst_level", queue_level, 4);
        serve(5);
        repeat (8) tick();
        check("burst_drained_level", queue_level, 0);
        check("burst_drained_busy", busy, 0);
        check("burst_overflow_sticky", overflow, 1);

        // Full queue with a write coinciding with the LOAD pop
        do_reset();
        for (int i = 0; i < 5; i++) send_pkt(16'(16'h2100 + i), 1'b1);
        check("sim_level_full", queue_level, 4);
        pulse_done();
        n_served++;
        repeat (2) tick();
        send_pkt(16'h7777, 1'b1);
        check("sim_level", queue_level, 4);
        check("sim_overflow", overflow, 0);
        check("sim_start", uart_start, 1);
        serve(5);
        repeat (8) tick();
        check("sim_drained_level", queue_level, 0);

        // Send timeout
        do_reset();
        send_pkt(16'hBEEF, 1'b1);
        send_pkt(16'hCAFE, 1'b1);
        wait_start(k);
        repeat (15) tick();
        check("to_err_early", timeout_err, 0);
        tick();
        check("to_err_set", timeout_err, 1);
        n_served++;
        wait_start(k);
        check("to_next_latency", k, 3);
        serve(1);
        repeat (6) tick();
        check("to_err_sticky", timeout_err, 1);
        check("to_busy_end", busy, 0);

        // Stall flush
        do_reset();
        demod_write = 1'b1;
        tick();
        demod_write = 1'b0;
        repeat (30) tick();
        check("flush_early", buffer_flush, 0);
        tick();
        check("flush_fire", buffer_flush, 1);
        n = 0;
        repeat (100) begin
            tick();
            if (buffer_flush === 1'b1) n++;
        end
        check("flush_no_refire", n, 0);
        demod_write = 1'b1;
        tick();
        demod_write = 1'b0;
        repeat (31) tick();
        check("flush_rearm", buffer_flush, 1);

        // Reset in the middle of WAIT
        do_reset();
        for (int i = 0; i < 6; i++) send_pkt(16'(16'h3000 + i), i < 5);
        check("rmw_overflow_pre", overflow, 1);
        check("rmw_busy_pre", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        n_served = n_start;
        check("rmw_busy", busy, 0);
        check("rmw_level", queue_level, 0);
        check("rmw_overflow", overflow, 0);
        check("rmw_uart_packet", uart_packet, 0);
        check("rmw_uart_start", uart_start, 0);
        pulse_done();
        n = 0;
        repeat (30) begin
            tick();
            if (uart_start === 1'b1) n++;
        end
        check("rmw_no_start", n, 0);
        check("rmw_busy_after", busy, 0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
